// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory stage of the 5-stage
// pipeline.
//   - default datapath, register-index and address widths
//   - FSM state enum for the data-memory access sequencer (IDLE, WAIT)
//   - EX/MEM and MEM/WB pipeline-register bundles
//   - is_memop(): does the instruction held in M touch data memory
`timescale 1ns/1ps

package mem_stage_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int REG_ADDR_W_DEF  = 5;
  localparam int ADDR_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Contents of the EX/MEM register. Control bits are stored raw; the M-stage
  // outputs are qualified by valid.
  typedef struct packed {
    logic                      valid;
    logic                      reg_wr;
    logic                      mem_wr;
    logic                      mem_rd;
    logic                      mem_to_reg;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [REG_ADDR_W_DEF-1:0] rb;
    logic [DATA_W_DEF-1:0]     alu_out;
    logic [DATA_W_DEF-1:0]     store_data;
  } ex_mem_t;

  // Contents of the MEM/WB register.
  typedef struct packed {
    logic                      reg_wr;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0]     bus_w;
  } mem_wb_t;

  function automatic logic is_memop(input logic valid, input logic mem_wr,
                                    input logic mem_rd);
    return valid & (mem_wr | mem_rd);
  endfunction

endpackage

// File: rtl/mem_stage_mem_access_fsm.sv
// mem_access_fsm: data-memory req/ack sequencer for the memory stage.
// Owns the access state, the captured store data (wdata_q), the optional
// timeout counter, dm_req and the stall request.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   memop           the M-stage instruction is a valid load or store
//   dm_ack          memory completes the access this cycle
//   wdata_idle      store data selected in the first cycle of an access
//   dm_req          memory request (combinational from memop)
//   mem_stall       freeze upstream stages and the EX/MEM register
//   access_timeout  access is being completed by timeout (load data -> 0)
//   dm_wdata        store data presented to memory
//   mem_err         sticky timeout flag (only with MEM_TIMEOUT_EN)
//
// Build option: define MEM_TIMEOUT_EN to complete an access on its own after
// TIMEOUT_CYC WAIT cycles without dm_ack. Undefined, WAIT lasts until dm_ack.
`timescale 1ns/1ps

module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memop,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] wdata_idle,
  output logic              dm_req,
  output logic              mem_stall,
  output logic              access_timeout,
  output logic [DATA_W-1:0] dm_wdata
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              mem_err
`endif
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_eff;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  // cnt_q counts completed WAIT cycles, so the TIMEOUT_CYC-th WAIT cycle is
  // the one that finishes the access.
  assign access_timeout = (state_q == WAIT) && !dm_ack &&
                          (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign mem_err        = mem_err_q;
`else
  assign access_timeout = 1'b0;
`endif

  assign ack_eff   = dm_ack | access_timeout;
  assign dm_req    = memop;
  // A same-cycle ack costs no stall cycle.
  assign mem_stall = memop & ~ack_eff;
  // WB bubbles once we stall, so a forwarded BusW_WB value is only trustworthy
  // in the first cycle; from WAIT on the captured copy is driven.
  assign dm_wdata  = (state_q == WAIT) ? wdata_q : wdata_idle;

  // NOTE: every always_comb target gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (memop && !ack_eff) begin
          state_d = WAIT;
          wdata_d = wdata_idle;
        end
      end
      WAIT: begin
        if (ack_eff) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  always_comb begin
    cnt_d     = (state_q == WAIT && !ack_eff) ? cnt_q + 1'b1 : '0;
    mem_err_d = mem_err_q | access_timeout;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
`endif
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage pipeline. Holds the EX/MEM and
// MEM/WB registers and sequences data-memory accesses through mem_access_fsm.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   Valid_EX..BusB_EX        EX-stage instruction fields
//   DiSrc                    replace store data with BusW_WB (WB forwarding)
//   RegWr_M, MemWr_M         M-stage control, qualified by valid
//   Rd_M, Rb_M, ALUout_M     M-stage indices / ALU result (forward sources)
//   RegWr_WB, Rd_WB, BusW_WB MEM/WB register (forward source, writeback)
//   MemStall                 freeze IF/ID/EX while an access is pending
//   dm_req/dm_we/dm_addr/dm_wdata, dm_ack/dm_rdata  data-memory handshake
//   MemErr                   sticky timeout flag (only with MEM_TIMEOUT_EN)
//
// Build option: MEM_TIMEOUT_EN enables the access timeout and the MemErr port.
// The pipeline bundles come from mem_stage_pkg, so DATA_W and REG_ADDR_W are
// expected to stay at the package widths; ADDR_W may be narrower than DATA_W.
`timescale 1ns/1ps

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid_EX,
  input  logic                  RegWr_EX,
  input  logic                  MemWr_EX,
  input  logic                  MemRd_EX,
  input  logic                  MemtoReg_EX,
  input  logic [REG_ADDR_W-1:0] Rd_EX,
  input  logic [REG_ADDR_W-1:0] Rb_EX,
  input  logic [DATA_W-1:0]     ALUout_EX,
  input  logic [DATA_W-1:0]     BusB_EX,
  input  logic                  DiSrc,
  output logic                  RegWr_M,
  output logic                  MemWr_M,
  output logic [REG_ADDR_W-1:0] Rd_M,
  output logic [REG_ADDR_W-1:0] Rb_M,
  output logic [DATA_W-1:0]     ALUout_M,
  output logic                  RegWr_WB,
  output logic [REG_ADDR_W-1:0] Rd_WB,
  output logic [DATA_W-1:0]     BusW_WB,
  output logic                  MemStall,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic                  dm_ack,
  input  logic [DATA_W-1:0]     dm_rdata
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                  MemErr
`endif
);

  ex_mem_t           ex_mem_q, ex_mem_d;
  mem_wb_t           mem_wb_q, mem_wb_d;
  logic              memop_m;
  logic              access_timeout;
  logic [DATA_W-1:0] wdata_idle;
  logic [DATA_W-1:0] rdata_eff;

  assign memop_m    = is_memop(ex_mem_q.valid, ex_mem_q.mem_wr, ex_mem_q.mem_rd);

  assign RegWr_M    = ex_mem_q.valid & ex_mem_q.reg_wr;
  assign MemWr_M    = ex_mem_q.valid & ex_mem_q.mem_wr;
  assign Rd_M       = ex_mem_q.rd;
  assign Rb_M       = ex_mem_q.rb;
  assign ALUout_M   = ex_mem_q.alu_out;

  assign RegWr_WB   = mem_wb_q.reg_wr;
  assign Rd_WB      = mem_wb_q.rd;
  assign BusW_WB    = mem_wb_q.bus_w;

  assign dm_we      = MemWr_M;
  assign dm_addr    = ex_mem_q.alu_out[ADDR_W-1:0];
  assign wdata_idle = DiSrc ? mem_wb_q.bus_w : ex_mem_q.store_data;
  // A timed-out load returns zero rather than whatever is on the bus.
  assign rdata_eff  = access_timeout ? '0 : dm_rdata;

  mem_access_fsm #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk            (clk),
    .rst            (rst),
    .memop          (memop_m),
    .dm_ack         (dm_ack),
    .wdata_idle     (wdata_idle),
    .dm_req         (dm_req),
    .mem_stall      (MemStall),
    .access_timeout (access_timeout),
    .dm_wdata       (dm_wdata)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_err        (MemErr)
`endif
  );

  always_comb begin
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (MemStall) begin
      // EX/MEM holds; WB receives a bubble but keeps its data and index.
      mem_wb_d.reg_wr = 1'b0;
    end else begin
      ex_mem_d.valid      = Valid_EX;
      ex_mem_d.reg_wr     = RegWr_EX;
      ex_mem_d.mem_wr     = MemWr_EX;
      ex_mem_d.mem_rd     = MemRd_EX;
      ex_mem_d.mem_to_reg = MemtoReg_EX;
      ex_mem_d.rd         = Rd_EX;
      ex_mem_d.rb         = Rb_EX;
      ex_mem_d.alu_out    = ALUout_EX;
      ex_mem_d.store_data = BusB_EX;

      mem_wb_d.reg_wr = RegWr_M;
      mem_wb_d.rd     = ex_mem_q.rd;
      mem_wb_d.bus_w  = (ex_mem_q.mem_to_reg & ex_mem_q.mem_rd) ? rdata_eff
                                                                : ex_mem_q.alu_out;
    end
  end

  // NOTE: both pipeline registers are plain flops (no storage arrays), so all
  // of them are cleared by reset and no X can leak into forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus a randomized run against a
// transaction-level reference model of the memory stage.
`timescale 1ns/1ps

module tb_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          Valid_EX, RegWr_EX, MemWr_EX, MemRd_EX, MemtoReg_EX;
  logic [RW-1:0] Rd_EX, Rb_EX;
  logic [DW-1:0] ALUout_EX, BusB_EX;
  logic          DiSrc;
  logic          RegWr_M, MemWr_M;
  logic [RW-1:0] Rd_M, Rb_M;
  logic [DW-1:0] ALUout_M;
  logic          RegWr_WB;
  logic [RW-1:0] Rd_WB;
  logic [DW-1:0] BusW_WB;
  logic          MemStall, dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
`ifdef MEM_TIMEOUT_EN
  logic          MemErr;
`endif

  int vectors     = 0;
  int miscompares = 0;

  mem_stage #(
    .DATA_W(DW), .REG_ADDR_W(RW), .ADDR_W(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .Valid_EX(Valid_EX), .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX),
    .MemRd_EX(MemRd_EX), .MemtoReg_EX(MemtoReg_EX),
    .Rd_EX(Rd_EX), .Rb_EX(Rb_EX), .ALUout_EX(ALUout_EX), .BusB_EX(BusB_EX),
    .DiSrc(DiSrc),
    .RegWr_M(RegWr_M), .MemWr_M(MemWr_M), .Rd_M(Rd_M), .Rb_M(Rb_M),
    .ALUout_M(ALUout_M), .RegWr_WB(RegWr_WB), .Rd_WB(Rd_WB), .BusW_WB(BusW_WB),
    .MemStall(MemStall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
`ifdef MEM_TIMEOUT_EN
    , .MemErr(MemErr)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic drive_ex(input logic v, input logic rw, input logic mw,
                          input logic mr, input logic m2r, input logic [RW-1:0] rd,
                          input logic [RW-1:0] rb, input logic [DW-1:0] alu,
                          input logic [DW-1:0] busb);
    Valid_EX = v; RegWr_EX = rw; MemWr_EX = mw; MemRd_EX = mr; MemtoReg_EX = m2r;
    Rd_EX = rd; Rb_EX = rb; ALUout_EX = alu; BusB_EX = busb;
  endtask

  task automatic bubble_ex();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bubble_ex();
    DiSrc = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------- scenarios
  task automatic test_reset();
    do_reset();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd3, 32'h0000_0AB0, 32'h1111_2222);
    next_cycle();
    bubble_ex();
    @(negedge clk);
    vectors++;
    if (dm_req !== 1'b1 || MemStall !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre: dm_req/MemStall got %b%b want 11", dm_req, MemStall);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({RegWr_M, MemWr_M, RegWr_WB, MemStall, dm_req, dm_we} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {RegWr_M, MemWr_M, RegWr_WB, MemStall, dm_req, dm_we});
    end
    vectors++;
    if ({Rd_M, Rb_M, Rd_WB} !== 15'd0 || ALUout_M !== '0 || BusW_WB !== '0) begin
      miscompares++;
      $display("FAIL reset_data: idx %h alu %h busw %h want zeros",
               {Rd_M, Rb_M, Rd_WB}, ALUout_M, BusW_WB);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 32'h0000_0100, '0);
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    next_cycle();
    bubble_ex();
    @(negedge clk);
    vectors++;
    if ({MemStall, dm_req, dm_we} !== 3'b010 || dm_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL load_req: stall/req/we %b addr %h want 010 addr 100",
               {MemStall, dm_req, dm_we}, dm_addr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (BusW_WB !== 32'hDEAD_BEEF || RegWr_WB !== 1'b1 || Rd_WB !== 5'd7) begin
      miscompares++;
      $display("FAIL load_wb: busw %h regwr %b rd %0d want deadbeef 1 7",
               BusW_WB, RegWr_WB, Rd_WB);
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_store_wait();
    do_reset();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 32'h11, '0);
    next_cycle();
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd6, 32'h200, 32'hCAFE_0001);
    next_cycle();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd1, 32'h77, '0);
    for (int c = 0; c < 4; c++) begin
      dm_ack = (c == 3);
      @(negedge clk);
      vectors++;
      if (MemStall !== (c < 3) || RegWr_WB !== (c == 0)) begin
        miscompares++;
        $display("FAIL store_stall c%0d: stall %b regwr_wb %b want %b %b",
                 c, MemStall, RegWr_WB, c < 3, c == 0);
      end
      vectors++;
      if ({dm_req, dm_we} !== 2'b11 || dm_addr !== 32'h200 ||
          dm_wdata !== 32'hCAFE_0001 || Rd_M !== 5'd3 || Rb_M !== 5'd6) begin
        miscompares++;
        $display("FAIL store_hold c%0d: req/we %b addr %h wdata %h rd %0d rb %0d want 11 200 cafe0001 3 6",
                 c, {dm_req, dm_we}, dm_addr, dm_wdata, Rd_M, Rb_M);
      end
      next_cycle();
    end
    dm_ack = 1'b0;
    bubble_ex();
    @(negedge clk);
    vectors++;
    if (RegWr_M !== 1'b1 || Rd_M !== 5'd9 || ALUout_M !== 32'h77 ||
        MemStall !== 1'b0 || RegWr_WB !== 1'b0) begin
      miscompares++;
      $display("FAIL store_after: regwr_m %b rd %0d alu %h stall %b regwr_wb %b want 1 9 77 0 0",
               RegWr_M, Rd_M, ALUout_M, MemStall, RegWr_WB);
    end
  endtask

  task automatic test_disrc_store();
    do_reset();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 32'h55, '0);
    next_cycle();
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 32'h300, 32'h99);
    next_cycle();
    bubble_ex();
    for (int c = 0; c < 3; c++) begin
      DiSrc  = (c == 0);
      dm_ack = (c == 2);
      @(negedge clk);
      vectors++;
      if (dm_wdata !== 32'h55 || MemStall !== (c < 2)) begin
        miscompares++;
        $display("FAIL disrc_wdata c%0d: wdata %h stall %b want 55 %b",
                 c, dm_wdata, MemStall, c < 2);
      end
      next_cycle();
    end
    DiSrc = 1'b0; dm_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] vpat = 5'b10101;
    do_reset();
    dm_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (vpat[i]) drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RW'(i + 1), '0, DW'(32'hA0 + i), '0);
      else         drive_ex(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, RW'(i + 1), '0, DW'(32'hA0 + i), '0);
      next_cycle();
      @(negedge clk);
      vectors++;
      if (RegWr_M !== vpat[i] || {MemWr_M, dm_req, MemStall} !== 3'b000 ||
          Rd_M !== RW'(i + 1)) begin
        miscompares++;
        $display("FAIL b2b_m i%0d: regwr_m %b memwr/req/stall %b rd %0d want %b 000 %0d",
                 i, RegWr_M, {MemWr_M, dm_req, MemStall}, Rd_M, vpat[i], i + 1);
      end
      if (i > 0) begin
        vectors++;
        if (RegWr_WB !== vpat[i-1] || BusW_WB !== DW'(32'hA0 + i - 1)) begin
          miscompares++;
          $display("FAIL b2b_wb i%0d: regwr_wb %b busw %h want %b %h",
                   i, RegWr_WB, BusW_WB, vpat[i-1], 32'hA0 + i - 1);
        end
      end
    end
    bubble_ex();
    dm_ack = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 32'h40, '0);
    next_cycle();
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 32'h500, 32'hABCD);
    next_cycle();
    bubble_ex();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (MemStall !== 1'b1 || dm_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rstwait_pre: stall %b req %b want 1 1", MemStall, dm_req);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({dm_req, MemStall, RegWr_WB} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstwait_drop: req/stall/regwr_wb %b want 000", {dm_req, MemStall, RegWr_WB});
    end
    next_cycle();
    rst = 1'b0;
    dm_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dm_req, MemStall} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstwait_ackidle: req/stall %b want 00", {dm_req, MemStall});
    end
    // A fresh store must see the IDLE-path data, proving the FSM left WAIT.
    dm_ack = 1'b0;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 32'h600, 32'h1234);
    next_cycle();
    bubble_ex();
    @(negedge clk);
    vectors++;
    if (dm_wdata !== 32'h1234 || MemStall !== 1'b1) begin
      miscompares++;
      $display("FAIL rstwait_idle: wdata %h stall %b want 1234 1", dm_wdata, MemStall);
    end
    dm_ack = 1'b1;
    next_cycle();
    dm_ack = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int stalls = 0;
    do_reset();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 32'h40, '0);
    dm_rdata = 32'hFFFF_FFFF;
    next_cycle();
    bubble_ex();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!MemStall) break;
      stalls++;
      next_cycle();
    end
    vectors++;
    if (stalls != TO) begin
      miscompares++;
      $display("FAIL timeout_len: stalled %0d cycles want %0d", stalls, TO);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (BusW_WB !== '0 || RegWr_WB !== 1'b1 || Rd_WB !== 5'd5 || MemErr !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_wb: busw %h regwr %b rd %0d err %b want 0 1 5 1",
               BusW_WB, RegWr_WB, Rd_WB, MemErr);
    end
    repeat (3) next_cycle();
    @(negedge clk);
    vectors++;
    if (MemErr !== 1'b1 || MemStall !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_sticky: err %b stall %b want 1 0", MemErr, MemStall);
    end
  endtask
`endif

  // Randomized run against a transaction-level model: the M slot and WB slot
  // are instruction records, and an outstanding access is a record of the
  // data promised to memory plus how long it has been waiting.
  task automatic test_random(input int n);
    logic          mv = 0, mrw = 0, mmw = 0, mmr = 0, mm2r = 0;
    logic [RW-1:0] mrd = '0, mrb = '0;
    logic [DW-1:0] malu = '0, msd = '0;
    logic          wrw = 0;
    logic [RW-1:0] wrd = '0;
    logic [DW-1:0] wbw = '0;
    logic          pend = 0, err = 0;
    logic [DW-1:0] held = '0;
    int            waited = 0;
    logic          memop, tmo, stall;
    logic [DW-1:0] exp_wdata;
    int            kind;
    do_reset();
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 3));
      drive_ex($urandom_range(0, 3) != 0, kind != 2, kind == 2, kind == 1,
               kind == 1 && $urandom_range(0, 3) != 0, RW'($urandom), RW'($urandom),
               $urandom, $urandom);
      DiSrc    = $urandom_range(0, 1) == 1;
      dm_ack   = $urandom_range(0, 2) == 0;
      dm_rdata = $urandom;
      @(negedge clk);
      memop = mv & (mmw | mmr);
`ifdef MEM_TIMEOUT_EN
      tmo = pend && !dm_ack && (waited == TO - 1);
`else
      tmo = 1'b0;
`endif
      stall     = memop & ~(dm_ack | tmo);
      exp_wdata = pend ? held : (DiSrc ? wbw : msd);
      vectors++;
      if ({RegWr_M, MemWr_M, RegWr_WB, MemStall, dm_req, dm_we} !==
          {mv & mrw, mv & mmw, wrw, stall, memop, mv & mmw}) begin
        miscompares++;
        $display("FAIL rand_ctrl #%0d: got %b want %b", i,
                 {RegWr_M, MemWr_M, RegWr_WB, MemStall, dm_req, dm_we},
                 {mv & mrw, mv & mmw, wrw, stall, memop, mv & mmw});
      end
      vectors++;
      if ({Rd_M, Rb_M, Rd_WB} !== {mrd, mrb, wrd} || ALUout_M !== malu ||
          dm_addr !== malu[AW-1:0]) begin
        miscompares++;
        $display("FAIL rand_m #%0d: idx %h alu %h addr %h want idx %h alu %h", i,
                 {Rd_M, Rb_M, Rd_WB}, ALUout_M, dm_addr, {mrd, mrb, wrd}, malu);
      end
      vectors++;
      if (BusW_WB !== wbw || dm_wdata !== exp_wdata) begin
        miscompares++;
        $display("FAIL rand_data #%0d: busw %h wdata %h want %h %h", i,
                 BusW_WB, dm_wdata, wbw, exp_wdata);
      end
`ifdef MEM_TIMEOUT_EN
      vectors++;
      if (MemErr !== err) begin
        miscompares++;
        $display("FAIL rand_err #%0d: got %b want %b", i, MemErr, err);
      end
`endif
      next_cycle();
      if (stall) begin
        if (!pend) begin pend = 1'b1; held = exp_wdata; waited = 0; end
        else waited++;
        wrw = 1'b0;
      end else begin
        pend = 1'b0; waited = 0;
        if (tmo) err = 1'b1;
        wrw = mv & mrw;
        wrd = mrd;
        wbw = (mm2r & mmr) ? (tmo ? '0 : dm_rdata) : malu;
        mv = Valid_EX; mrw = RegWr_EX; mmw = MemWr_EX; mmr = MemRd_EX;
        mm2r = MemtoReg_EX; mrd = Rd_EX; mrb = Rb_EX; malu = ALUout_EX; msd = BusB_EX;
      end
    end
    bubble_ex();
    dm_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bubble_ex();
    DiSrc = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    test_reset();
    test_load();
    test_store_wait();
    test_disrc_store();
    test_back_to_back();
    test_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
